// File: rtl/traffic_controller_actuated.sv
// Vehicle-actuated controller for a two-road junction.
// A prescaled tick timer and the light FSM live in one block.
// NS is the rest road. EW is served on a car or on a latched pedestrian request.
// Minimum and maximum green, yellow and all-red clearance are counted in ticks.
// Lamps and walk are registered and decoded from the next state.
module traffic_controller_actuated #(
   parameter int TICK_DIV  = 4,
   parameter int CNT_W     = 8,
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 10,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_carNS,
   input  logic       i_carEW,
   input  logic       i_ped,
   output logic [2:0] o_NSlights,
   output logic [2:0] o_EWlights,
   output logic       o_walk,
   output logic [2:0] o_state
);

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALLRED_A  = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALLRED_B  = 3'd5
   } state_t;

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [2:0] LAMP_RED = 3'b100;
   localparam logic [2:0] LAMP_YEL = 3'b010;
   localparam logic [2:0] LAMP_GRN = 3'b001;

   // The state register is a raw 3-bit code so that codes 6 and 7 can exist and be recovered from.
   logic [2:0]       state;
   state_t           next_state;
   logic [PRE_W-1:0] presc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_eff;
   logic [1:0]       sync_ns;
   logic [1:0]       sync_ew;
   logic [1:0]       sync_ped;
   logic             ped_prev;
   logic             ped_latch;
   logic             car_ns;
   logic             car_ew;
   logic             ped;
   logic             ped_rise;
   logic             tick;
   logic             min_done;
   logic             at_max;
   logic             ew_demand;
   logic             state_chg;
   logic             enter_ew;
   logic             walk_next;
   logic [2:0]       ns_next;
   logic [2:0]       ew_next;

   assign car_ns    = sync_ns[1];
   assign car_ew    = sync_ew[1];
   assign ped       = sync_ped[1];
   assign ped_rise  = ped & ~ped_prev;
   assign tick      = (presc == PRE_W'(TICK_DIV - 1));
   // The count as it will be after this edge, so that a tick and new demand act on the same edge.
   assign cnt_eff   = (tick && (cnt != CNT_W'(GREEN_MAX))) ? cnt + CNT_W'(1) : cnt;
   assign min_done  = (cnt_eff >= CNT_W'(GREEN_MIN));
   assign at_max    = (cnt_eff == CNT_W'(GREEN_MAX));
   assign ew_demand = car_ew | ped_latch;
   assign state_chg = (next_state != state);
   assign enter_ew  = (next_state == EW_GREEN) && (state != EW_GREEN);
   assign o_state   = state;

   // Two-flop synchronisers for the asynchronous sensors and button, plus the ped edge history.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync_ns  <= '0;
         sync_ew  <= '0;
         sync_ped <= '0;
         ped_prev <= 1'b0;
      end else begin
         sync_ns  <= {sync_ns[0], i_carNS};
         sync_ew  <= {sync_ew[0], i_carEW};
         sync_ped <= {sync_ped[0], i_ped};
         ped_prev <= ped;
      end
   end

   // Next-state selection: greens give way on cross demand, and amber/all-red phases run on timers.
   always_comb begin
      next_state = NS_GREEN;
      case (state)
         NS_GREEN:  next_state = (min_done && ew_demand && (!car_ns || at_max)) ? NS_YELLOW : NS_GREEN;
         NS_YELLOW: next_state = (cnt_eff >= CNT_W'(YELLOW_T)) ? ALLRED_A : NS_YELLOW;
         ALLRED_A:  next_state = (cnt_eff >= CNT_W'(ALLRED_T)) ? EW_GREEN : ALLRED_A;
         EW_GREEN:  next_state = (min_done && ((car_ns && (!car_ew || at_max)) ||
                                               (!car_ns && !car_ew && !ped_latch))) ? EW_YELLOW : EW_GREEN;
         EW_YELLOW: next_state = (cnt_eff >= CNT_W'(YELLOW_T)) ? ALLRED_B : EW_YELLOW;
         ALLRED_B:  next_state = (cnt_eff >= CNT_W'(ALLRED_T)) ? NS_GREEN : ALLRED_B;
         default:   next_state = NS_GREEN;
      endcase
   end

   // Lamp decode of the next state; every non-green road shows red.
   always_comb begin
      ns_next = LAMP_RED;
      ew_next = LAMP_RED;
      case (next_state)
         NS_GREEN:  ns_next = LAMP_GRN;
         NS_YELLOW: ns_next = LAMP_YEL;
         EW_GREEN:  ew_next = LAMP_GRN;
         EW_YELLOW: ew_next = LAMP_YEL;
         default:   ns_next = LAMP_RED;
      endcase
   end

   // Walk lights on EW entry if a request was latched, and holds only through the minimum green.
   assign walk_next = (next_state == EW_GREEN) &&
                      (enter_ew ? ped_latch : (o_walk && (cnt_eff < CNT_W'(GREEN_MIN))));

   // State, timer, pedestrian latch and registered outputs.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state      <= NS_GREEN;
         presc      <= '0;
         cnt        <= '0;
         ped_latch  <= 1'b0;
         o_NSlights <= LAMP_GRN;
         o_EWlights <= LAMP_RED;
         o_walk     <= 1'b0;
      end else begin
         state <= next_state;
         if (state_chg) begin
            presc <= '0;
            cnt   <= '0;
         end else begin
            presc <= tick ? '0 : presc + PRE_W'(1);
            cnt   <= cnt_eff;
         end
         // Clearing on EW entry takes priority over a coincident new press.
         if (enter_ew)
            ped_latch <= 1'b0;
         else if (ped_rise)
            ped_latch <= 1'b1;
         o_NSlights <= ns_next;
         o_EWlights <= ew_next;
         o_walk     <= walk_next;
      end
   end

endmodule

// File: tb/tb_traffic_controller_actuated.sv
// Bench for traffic_controller_actuated: a scoreboard of expected phases
// (code, length in cycles, walk cycles) checked as each phase ends, plus lamp sanity every cycle.
module tb_traffic_controller_actuated;

   localparam int TICK_DIV  = 4;
   localparam int GREEN_MIN = 4;
   localparam int GREEN_MAX = 10;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;
   localparam int MIN_C     = GREEN_MIN * TICK_DIV;
   localparam int MAX_C     = GREEN_MAX * TICK_DIV;
   localparam int YEL_C     = YELLOW_T * TICK_DIV;
   localparam int AR_C      = ALLRED_T * TICK_DIV;

   logic       i_clk   = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_carNS = 1'b0;
   logic       i_carEW = 1'b0;
   logic       i_ped   = 1'b0;
   logic [2:0] o_NSlights;
   logic [2:0] o_EWlights;
   logic       o_walk;
   logic [2:0] o_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_q[$];
   logic        mon_off  = 1'b0;
   logic [2:0]  cur      = 3'd0;
   int          seg_len  = 0;
   int          walk_len = 0;
   logic [31:0] e;

   traffic_controller_actuated #(
      .TICK_DIV(TICK_DIV), .CNT_W(8), .GREEN_MIN(GREEN_MIN),
      .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
   ) dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_carNS(i_carNS), .i_carEW(i_carEW),
      .i_ped(i_ped), .o_NSlights(o_NSlights), .o_EWlights(o_EWlights),
      .o_walk(o_walk), .o_state(o_state)
   );

   // Clock
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] seg(input logic [2:0] code, input int len, input int walk);
      return {code, 13'(walk), 16'(len)};
   endfunction

   // Monitor: lamp sanity every cycle, and phase closure against the expected queue.
   always @(posedge i_clk) begin
      #1;
      check("ns_onehot", 32'($countones(o_NSlights)), 32'd1);
      check("ew_onehot", 32'($countones(o_EWlights)), 32'd1);
      check("one_road_red", 32'(o_NSlights[2] | o_EWlights[2]), 32'd1);
      if (i_reset || mon_off) begin
         cur      = o_state;
         seg_len  = 1;
         walk_len = 0;
      end else if (o_state != cur) begin
         if (exp_q.size() == 0) begin
            check("quiet", 32'(o_state), 32'(cur));
         end else begin
            e = exp_q.pop_front();
            check("seg_code", 32'(cur), 32'(e[31:29]));
            check("seg_len", 32'(seg_len), 32'(e[15:0]));
            check("seg_walk", 32'(walk_len), 32'(e[28:16]));
         end
         cur      = o_state;
         seg_len  = 1;
         walk_len = int'(o_walk);
      end else begin
         seg_len++;
         walk_len += int'(o_walk);
      end
   end

   task automatic reset_on(input logic ns, input logic ew);
      @(negedge i_clk);
      i_reset = 1'b1;
      i_carNS = ns;
      i_carEW = ew;
      i_ped   = 1'b0;
      exp_q.delete();
      #1;
      mon_off = 1'b0;
   endtask

   task automatic reset_off();
      repeat (3) @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   task automatic check_lamps(input string tag, input logic [2:0] st, input logic [2:0] ns,
                              input logic [2:0] ew, input logic walk);
      check({tag, "_state"}, 32'(o_state), 32'(st));
      check({tag, "_ns"}, 32'(o_NSlights), 32'(ns));
      check({tag, "_ew"}, 32'(o_EWlights), 32'(ew));
      check({tag, "_walk"}, 32'(o_walk), 32'(walk));
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] code, input int budget);
      int n = 0;
      while (o_state != code && n < budget) begin
         @(negedge i_clk);
         n++;
      end
      check({tag, "_reach"}, 32'(o_state), 32'(code));
   endtask

   task automatic ped_pulse();
      i_ped = 1'b1;
      @(negedge i_clk);
      i_ped = 1'b0;
   endtask

   // Stimulus and expectations
   initial begin
      // Idle after reset: rests in NS green
      reset_on(1'b0, 1'b0);
      check_lamps("rst", 3'd0, 3'b001, 3'b100, 1'b0);
      reset_off();
      repeat (200) @(negedge i_clk);
      check_lamps("idle", 3'd0, 3'b001, 3'b100, 1'b0);

      // EW car only: minimum green, then amber and clearance into EW green
      reset_on(1'b0, 1'b1);
      reset_off();
      exp_q.push_back(seg(3'd0, MIN_C, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      exp_q.push_back(seg(3'd2, AR_C, 0));
      wait_drain("ewcar", 200);
      wait_state("ewcar", 3'd3, 10);
      check_lamps("ewgreen", 3'd3, 3'b100, 3'b001, 1'b0);
      repeat (10) @(negedge i_clk);
      // Reset in the middle of EW green acts at once
      i_reset = 1'b1;
      #1;
      check_lamps("midreset", 3'd0, 3'b001, 3'b100, 1'b0);
      reset_off();
      exp_q.push_back(seg(3'd0, MIN_C, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      exp_q.push_back(seg(3'd2, AR_C, 0));
      wait_drain("ewcar2", 200);
      wait_state("ewcar2", 3'd3, 10);
      repeat (5) @(negedge i_clk);

      // Illegal code 6 recovers to NS green on the next edge
      mon_off = 1'b1;
      force dut.state = 3'd6;
      @(posedge i_clk);
      #1;
      check("illegal_ns", 32'(o_NSlights), 32'(3'b001));
      check("illegal_ew", 32'(o_EWlights), 32'(3'b100));
      release dut.state;
      @(posedge i_clk);
      #1;
      check("illegal_state", 32'(o_state), 32'd0);

      // Both cars held: each green runs to its maximum, full loop
      reset_on(1'b1, 1'b1);
      reset_off();
      exp_q.push_back(seg(3'd0, MAX_C, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      exp_q.push_back(seg(3'd2, AR_C, 0));
      exp_q.push_back(seg(3'd3, MAX_C, 0));
      exp_q.push_back(seg(3'd4, YEL_C, 0));
      exp_q.push_back(seg(3'd5, AR_C, 0));
      exp_q.push_back(seg(3'd0, MAX_C, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      wait_drain("loop", 400);

      // Single ped pulse, no cars: one EW phase with walk, then rest in NS
      reset_on(1'b0, 1'b0);
      reset_off();
      exp_q.push_back(seg(3'd0, 24, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      exp_q.push_back(seg(3'd2, AR_C, 0));
      exp_q.push_back(seg(3'd3, MIN_C, MIN_C));
      exp_q.push_back(seg(3'd4, YEL_C, 0));
      exp_q.push_back(seg(3'd5, AR_C, 0));
      repeat (20) @(negedge i_clk);
      ped_pulse();
      wait_drain("ped", 200);
      repeat (60) @(negedge i_clk);
      check_lamps("ped_rest", 3'd0, 3'b001, 3'b100, 1'b0);

      // Press during EW green is kept and served by a second EW phase
      reset_on(1'b0, 1'b0);
      reset_off();
      exp_q.push_back(seg(3'd0, 24, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      exp_q.push_back(seg(3'd2, AR_C, 0));
      exp_q.push_back(seg(3'd3, MIN_C, MIN_C));
      exp_q.push_back(seg(3'd4, YEL_C, 0));
      exp_q.push_back(seg(3'd5, AR_C, 0));
      exp_q.push_back(seg(3'd0, MIN_C, 0));
      exp_q.push_back(seg(3'd1, YEL_C, 0));
      exp_q.push_back(seg(3'd2, AR_C, 0));
      exp_q.push_back(seg(3'd3, MIN_C, MIN_C));
      exp_q.push_back(seg(3'd4, YEL_C, 0));
      exp_q.push_back(seg(3'd5, AR_C, 0));
      repeat (20) @(negedge i_clk);
      ped_pulse();
      wait_state("ped2_ew", 3'd3, 100);
      repeat (4) @(negedge i_clk);
      i_carNS = 1'b1;
      ped_pulse();
      wait_state("ped2_ewy", 3'd4, 100);
      i_carNS = 1'b0;
      wait_drain("ped2", 300);
      repeat (40) @(negedge i_clk);
      check_lamps("ped2_rest", 3'd0, 3'b001, 3'b100, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
